i_decode: RTL and testbench
===========================

Name: i_decode

Overview:
Decode stage directly downstream of instruction fetch. It accepts one 32-bit instruction per fetch pulse and decodes the scalar RV32I subset and the RVV subset into a registered micro-op. It holds that micro-op until the dispatch/scoreboard stage takes it, and advertises vacancy back to fetch.

Parameters:
XLEN, 32, scalar data/immediate width
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  one-cycle pulse from fetch: id_inst valid
id_inst  in  32  raw instruction
id_vacant  out  1  decode buffer empty; fetch may send
is_valid  out  1  decoded micro-op available
is_ready  in  1  dispatch accepts micro-op this cycle
is_class  out  4  op class (OPC_* constants)
is_illegal  out  1  unsupported encoding
is_rd  out  REG_W  destination index (vd, or vs3 for vector store)
is_rs1  out  REG_W  source 1 index
is_rs2  out  REG_W  source 2 index (vs2 for vector)
is_rd_wen  out  1  instruction writes rd
is_rs1_used  out  1  rs1 read
is_rs2_used  out  1  rs2 read
is_vec_dst  out  1  rd is vector register
is_vec_src  out  1  rs2/vs3 are vector registers
is_funct3  out  3  inst[14:12]
is_funct6  out  6  inst[31:26] (funct7[6:1] for scalar)
is_vm  out  1  inst[25]
is_imm  out  XLEN  extended immediate

Behaviour:
- Clock and reset decided: single clock clk; rst asynchronous, active-high.
- Reset (asynchronous, any time, including mid-hold): id_vacant=1; is_valid=0; all other outputs 0. Any buffered op is discarded.
- States:
  - EMPTY: id_vacant=1.
  - FULL: id_vacant=0, is_valid=1.
- EMPTY -> FULL: at the posedge where id_valid=1. All is_* fields are decoded combinationally from id_inst and registered on that edge. Latency is 1 cycle from the id_valid sample to is_valid.
- FULL -> EMPTY: at the posedge where is_ready=1. is_valid and id_vacant change on the same edge.
- In FULL, all is_* outputs are held stable regardless of is_ready.
- id_vacant and is_valid are registered and are exact complements.
- Fetch protocol: fetch samples id_vacant and then pulses id_valid once. Decode must capture every pulse received in EMPTY.
  - id_valid in FULL is a protocol violation. The held op is kept, the new instruction is dropped, and a simulation assertion fires.
- No same-cycle accept-and-refill: EMPTY is always visible for at least one cycle.
- Decode table (opcode inst[6:0]); anything not listed gives class OPC_NONE, is_illegal=1, all enables 0:
  - 0110111 LUI -> OPC_ALU; rd_wen. imm = {inst[31:12], 12'b0}.
  - 0010011 OP-IMM -> OPC_ALU; rd_wen, rs1. imm = I-type sign-extended.
  - 0110011 OP -> OPC_ALU; rd_wen, rs1, rs2.
  - 0000011 LOAD -> OPC_LOAD; rd_wen, rs1. I-imm.
  - 0100011 STORE -> OPC_STORE; rs1, rs2. S-imm.
  - 1100011 with funct3=001 (bne) -> OPC_BRANCH; rs1, rs2; rd forced to 0; rd_wen=0. B-imm, 13-bit sign-extended.
    - Other branch funct3 values are illegal.
    - The branch resolves through writeback with rd=0, which is what fetch watches.
  - 1010111 OP-V:
    - funct3=111 -> OPC_VSET; rd_wen, rs1. Scalar dst; vec_dst=0.
      - inst[31]=0 (vsetvli): imm = zero-extended inst[30:20].
      - inst[31]=1 (vsetvl): rs2_used=1.
    - funct3=000 OPIVV -> OPC_VALU; vec_dst, vec_src; rs1 (vector), rs2.
    - funct3=100 OPIVX -> OPC_VALU; rs1 is scalar.
    - funct3=011 OPIVI -> OPC_VALU; rs1_used=0; imm = sign-extended inst[19:15].
    - Other OP-V funct3 values are illegal.
  - 0000111 -> OPC_VLOAD; vec_dst, rd_wen, rs1 scalar base.
  - 0100111 -> OPC_VSTORE; rd = vs3; rd_wen=0; vec_src; rs1 scalar base.
- Illegal ops are still presented with is_valid=1 so downstream can trap; they are never dropped.

Decomposition:
- macros.v holds:
  - OPC_NONE=0, OPC_ALU=1, OPC_LOAD=2, OPC_STORE=3, OPC_BRANCH=4, OPC_VALU=5, OPC_VLOAD=6, OPC_VSTORE=7, OPC_VSET=8;
  - opcode constants;
  - OPC_WID (3:0).
- Sub-module imm_gen (combinational): selects and extends I/S/B/U/simm5/zimm11 from inst and an imm-type select.
- The handshake register and decode table stay in i_decode.

Test Plan:
- Reset, then id_inst=0x00500093 (addi x1,x0,5) pulse with is_ready=1 -> next cycle is_valid=1, class ALU, rd=1, rs1=0, imm=5, rd_wen=1; EMPTY one cycle later.
- 0xFE209CE3 (bne x1,x2,-8) -> class BRANCH, rs1=1, rs2=2, rd=0, rd_wen=0, imm=0xFFFFFFF8.
- 0x022081D7 (vadd.vv v3,v1,v2) -> class VALU, rd=3, rs1=1, rs2=2, vm=1, vec_dst=1, vec_src=1.
- 0x0000006F (jal) -> is_valid=1, is_illegal=1, class NONE, all enables 0.
- Hold is_ready=0 for 3 cycles after capture -> outputs unchanged, id_vacant=0 throughout; is_ready=1 -> id_vacant=1 on the following edge.
- Assert rst asynchronously while FULL, between clock edges -> is_valid=0, id_vacant=1 immediately; the next instruction decodes correctly.

Source files
------------

// File: rtl/i_decode_pkg.sv
// Shared constants and types for the decode stage: op classes, major opcodes,
// immediate-format selects and the registered micro-op record.
package i_decode_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_W_DEF = 5;
  localparam int OPC_WID   = 4;

  localparam logic [OPC_WID-1:0] OPC_NONE   = 4'd0;
  localparam logic [OPC_WID-1:0] OPC_ALU    = 4'd1;
  localparam logic [OPC_WID-1:0] OPC_LOAD   = 4'd2;
  localparam logic [OPC_WID-1:0] OPC_STORE  = 4'd3;
  localparam logic [OPC_WID-1:0] OPC_BRANCH = 4'd4;
  localparam logic [OPC_WID-1:0] OPC_VALU   = 4'd5;
  localparam logic [OPC_WID-1:0] OPC_VLOAD  = 4'd6;
  localparam logic [OPC_WID-1:0] OPC_VSTORE = 4'd7;
  localparam logic [OPC_WID-1:0] OPC_VSET   = 4'd8;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_V      = 7'b1010111;
  localparam logic [6:0] OP_VL     = 7'b0000111;
  localparam logic [6:0] OP_VS     = 7'b0100111;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_SIMM5, IMM_ZIMM11
  } imm_sel_e;

  typedef struct packed {
    logic [OPC_WID-1:0]   cls;
    logic                 illegal;
    logic [REG_W_DEF-1:0] rd;
    logic [REG_W_DEF-1:0] rs1;
    logic [REG_W_DEF-1:0] rs2;
    logic                 rd_wen;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 vec_dst;
    logic                 vec_src;
    logic [2:0]           funct3;
    logic [5:0]           funct6;
    logic                 vm;
    logic [XLEN_DEF-1:0]  imm;
  } uop_t;

endpackage

// File: rtl/i_decode_imm_gen.sv
// Immediate extraction and extension for the decode stage (purely combinational).
module i_decode_imm_gen
  import i_decode_pkg::*;
(
  input  logic [31:0]         inst_i,
  input  imm_sel_e            sel_i,
  output logic [XLEN_DEF-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    unique case (sel_i)
      IMM_I:      imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:      imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:      imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                           inst_i[11:8], 1'b0};
      IMM_U:      imm_o = {inst_i[31:12], 12'b0};
      IMM_SIMM5:  imm_o = {{27{inst_i[19]}}, inst_i[19:15]};
      IMM_ZIMM11: imm_o = {21'b0, inst_i[30:20]};
      default:    imm_o = '0;
    endcase
  end

endmodule

// File: rtl/i_decode.sv
// Decode stage: one-entry buffer between fetch and dispatch holding a decoded
// RV32I/RVV micro-op. State table: EMPTY | ready for fetch ; FULL | op held for dispatch.
module i_decode
  import i_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [31:0]        id_inst,
  output logic               id_vacant,
  output logic               is_valid,
  input  logic               is_ready,
  output logic [3:0]         is_class,
  output logic               is_illegal,
  output logic [REG_W-1:0]   is_rd,
  output logic [REG_W-1:0]   is_rs1,
  output logic [REG_W-1:0]   is_rs2,
  output logic               is_rd_wen,
  output logic               is_rs1_used,
  output logic               is_rs2_used,
  output logic               is_vec_dst,
  output logic               is_vec_src,
  output logic [2:0]         is_funct3,
  output logic [5:0]         is_funct6,
  output logic               is_vm,
  output logic [XLEN-1:0]    is_imm
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e        state_q, state_d;
  uop_t          uop_q, uop_d, dec;
  imm_sel_e      imm_sel;
  logic [XLEN_DEF-1:0] imm;

  i_decode_imm_gen u_imm_gen (
    .inst_i (id_inst),
    .sel_i  (imm_sel),
    .imm_o  (imm)
  );

  // Register fields are passed through raw; only enables/class depend on the opcode.
  always_comb begin
    dec          = '0;
    imm_sel      = IMM_NONE;
    dec.cls      = OPC_NONE;
    dec.illegal  = 1'b1;
    dec.rd       = id_inst[11:7];
    dec.rs1      = id_inst[19:15];
    dec.rs2      = id_inst[24:20];
    dec.funct3   = id_inst[14:12];
    dec.funct6   = id_inst[31:26];
    dec.vm       = id_inst[25];
    unique case (id_inst[6:0])
      OP_LUI: begin
        dec.cls = OPC_ALU; dec.illegal = 1'b0; dec.rd_wen = 1'b1; imm_sel = IMM_U;
      end
      OP_IMM: begin
        dec.cls = OPC_ALU; dec.illegal = 1'b0; dec.rd_wen = 1'b1; dec.rs1_used = 1'b1;
        imm_sel = IMM_I;
      end
      OP_OP: begin
        dec.cls = OPC_ALU; dec.illegal = 1'b0; dec.rd_wen = 1'b1; dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      OP_LOAD: begin
        dec.cls = OPC_LOAD; dec.illegal = 1'b0; dec.rd_wen = 1'b1; dec.rs1_used = 1'b1;
        imm_sel = IMM_I;
      end
      OP_STORE: begin
        dec.cls = OPC_STORE; dec.illegal = 1'b0; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
        imm_sel = IMM_S;
      end
      OP_BRANCH: begin
        if (id_inst[14:12] == 3'b001) begin
          dec.cls = OPC_BRANCH; dec.illegal = 1'b0; dec.rs1_used = 1'b1;
          dec.rs2_used = 1'b1; dec.rd = '0; imm_sel = IMM_B;
        end
      end
      OP_V: begin
        unique case (id_inst[14:12])
          3'b111: begin
            dec.cls = OPC_VSET; dec.illegal = 1'b0; dec.rd_wen = 1'b1; dec.rs1_used = 1'b1;
            if (id_inst[31]) dec.rs2_used = 1'b1;
            else             imm_sel = IMM_ZIMM11;
          end
          3'b000, 3'b100: begin
            dec.cls = OPC_VALU; dec.illegal = 1'b0; dec.rd_wen = 1'b1; dec.vec_dst = 1'b1;
            dec.vec_src = 1'b1; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
          end
          3'b011: begin
            dec.cls = OPC_VALU; dec.illegal = 1'b0; dec.rd_wen = 1'b1; dec.vec_dst = 1'b1;
            dec.vec_src = 1'b1; dec.rs2_used = 1'b1; imm_sel = IMM_SIMM5;
          end
          default: ;
        endcase
      end
      OP_VL: begin
        dec.cls = OPC_VLOAD; dec.illegal = 1'b0; dec.rd_wen = 1'b1; dec.vec_dst = 1'b1;
        dec.rs1_used = 1'b1;
      end
      OP_VS: begin
        dec.cls = OPC_VSTORE; dec.illegal = 1'b0; dec.vec_src = 1'b1; dec.rs1_used = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    uop_d   = uop_q;
    unique case (state_q)
      ST_EMPTY: if (id_valid) begin
        state_d   = ST_FULL;
        uop_d     = dec;
        uop_d.imm = imm;
      end
      ST_FULL: if (is_ready) state_d = ST_EMPTY;
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      uop_q   <= '0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
    end
  end

  a_no_fetch_when_full: assert property (@(posedge clk) disable iff (rst)
    !(state_q == ST_FULL && id_valid))
    else $error("id_valid received while decode buffer is full");

  assign id_vacant   = (state_q == ST_EMPTY);
  assign is_valid    = (state_q == ST_FULL);
  assign is_class    = uop_q.cls;
  assign is_illegal  = uop_q.illegal;
  assign is_rd       = uop_q.rd;
  assign is_rs1      = uop_q.rs1;
  assign is_rs2      = uop_q.rs2;
  assign is_rd_wen   = uop_q.rd_wen;
  assign is_rs1_used = uop_q.rs1_used;
  assign is_rs2_used = uop_q.rs2_used;
  assign is_vec_dst  = uop_q.vec_dst;
  assign is_vec_src  = uop_q.vec_src;
  assign is_funct3   = uop_q.funct3;
  assign is_funct6   = uop_q.funct6;
  assign is_vm       = uop_q.vm;
  assign is_imm      = uop_q.imm;

endmodule

// File: tb/tb_i_decode.sv
// Self-checking bench for i_decode: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural decode model.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        id_vacant, is_valid, is_ready;
  logic [3:0]  is_class;
  logic        is_illegal;
  logic [4:0]  is_rd, is_rs1, is_rs2;
  logic        is_rd_wen, is_rs1_used, is_rs2_used, is_vec_dst, is_vec_src;
  logic [2:0]  is_funct3;
  logic [5:0]  is_funct6;
  logic        is_vm;
  logic [31:0] is_imm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i_decode #(.XLEN(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .id_vacant(id_vacant), .is_valid(is_valid), .is_ready(is_ready),
    .is_class(is_class), .is_illegal(is_illegal), .is_rd(is_rd), .is_rs1(is_rs1),
    .is_rs2(is_rs2), .is_rd_wen(is_rd_wen), .is_rs1_used(is_rs1_used),
    .is_rs2_used(is_rs2_used), .is_vec_dst(is_vec_dst), .is_vec_src(is_vec_src),
    .is_funct3(is_funct3), .is_funct6(is_funct6), .is_vm(is_vm), .is_imm(is_imm)
  );

  typedef struct {
    int unsigned cls;
    bit          ill;
    int unsigned rd, rs1, rs2;
    bit          wen, r1u, r2u, vd, vs;
    int unsigned f3, f6;
    bit          vm;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_op;
  bit   exp_full = 0;

  // Behavioural reference: table lookup on opcode, immediates via signed shifts.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [31:0] i_imm, s_imm;
    int unsigned op, f3;
    op    = w[6:0];
    f3    = w[14:12];
    i_imm = 32'($signed(w) >>> 20);
    s_imm = {i_imm[31:5], w[11:7]};
    e = '{cls: 0, ill: 1, rd: w[11:7], rs1: w[19:15], rs2: w[24:20], wen: 0, r1u: 0,
          r2u: 0, vd: 0, vs: 0, f3: f3, f6: w[31:26], vm: w[25], imm: 32'h0};
    case (op)
      'h37: begin e.cls = 1; e.ill = 0; e.wen = 1; e.imm = w & 32'hFFFF_F000; end
      'h13: begin e.cls = 1; e.ill = 0; e.wen = 1; e.r1u = 1; e.imm = i_imm; end
      'h33: begin e.cls = 1; e.ill = 0; e.wen = 1; e.r1u = 1; e.r2u = 1; end
      'h03: begin e.cls = 2; e.ill = 0; e.wen = 1; e.r1u = 1; e.imm = i_imm; end
      'h23: begin e.cls = 3; e.ill = 0; e.r1u = 1; e.r2u = 1; e.imm = s_imm; end
      'h63: if (f3 == 1) begin
        e.cls = 4; e.ill = 0; e.r1u = 1; e.r2u = 1; e.rd = 0;
        e.imm = (s_imm & ~32'h801) | (32'(w[7]) << 11);
      end
      'h57: begin
        if (f3 == 7) begin
          e.cls = 8; e.ill = 0; e.wen = 1; e.r1u = 1;
          if (w[31]) e.r2u = 1; else e.imm = (w >> 20) & 32'h7FF;
        end else if (f3 == 0 || f3 == 4 || f3 == 3) begin
          e.cls = 5; e.ill = 0; e.wen = 1; e.vd = 1; e.vs = 1; e.r2u = 1;
          e.r1u = (f3 != 3);
          if (f3 == 3) e.imm = 32'($signed(w << 12) >>> 27);
        end
      end
      'h07: begin e.cls = 6; e.ill = 0; e.wen = 1; e.vd = 1; e.r1u = 1; end
      'h27: begin e.cls = 7; e.ill = 0; e.vs = 1; e.r1u = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 32'(is_valid), 32'(exp_full));
      chk("vacant", 32'(id_vacant), 32'(!exp_full));
      if (exp_full) begin
        chk("class", 32'(is_class), exp_op.cls);
        chk("illegal", 32'(is_illegal), 32'(exp_op.ill));
        chk("rd", 32'(is_rd), exp_op.rd);
        chk("rs1", 32'(is_rs1), exp_op.rs1);
        chk("rs2", 32'(is_rs2), exp_op.rs2);
        chk("enables", {27'b0, is_rd_wen, is_rs1_used, is_rs2_used, is_vec_dst, is_vec_src},
            {27'b0, exp_op.wen, exp_op.r1u, exp_op.r2u, exp_op.vd, exp_op.vs});
        chk("funct3", 32'(is_funct3), exp_op.f3);
        chk("funct6", 32'(is_funct6), exp_op.f6);
        chk("vm", 32'(is_vm), 32'(exp_op.vm));
        chk("imm", is_imm, exp_op.imm);
      end
    end
  end

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cycle(input bit v, input logic [31:0] w, input bit rdy);
    id_valid = v;
    id_inst  = w;
    is_ready = rdy;
    @(posedge clk);
    if (exp_full) begin
      if (rdy) exp_full = 0;
    end else if (v) begin
      exp_full = 1;
      exp_op   = model(w);
    end
    @(negedge clk);
    id_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  ops [9];
    logic [2:0]  vf3 [4];
    int k;
    ops = '{7'h37, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h57, 7'h07, 7'h27};
    vf3 = '{3'b111, 3'b000, 3'b100, 3'b011};
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) r[6:0] = ops[k];
    if (k == 5 && $urandom_range(0, 1) == 1) r[14:12] = 3'b001;
    if (k == 6 && $urandom_range(0, 4) != 0) r[14:12] = vf3[$urandom_range(0, 3)];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected done by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    rst = 1'b1; id_valid = 1'b0; id_inst = '0; is_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vacant", 32'(id_vacant), 32'd1);
    chk("rst_valid", 32'(is_valid), 32'd0);
    chk("rst_imm", is_imm, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pin the model against hand-decoded values.
    m = model(32'hFE209CE3);
    chk("model_bne_imm", m.imm, 32'hFFFF_FFF8);
    m = model(32'h00500093);
    chk("model_addi_imm", m.imm, 32'd5);

    cycle(1, 32'h00500093, 1);
    chk("addi_valid", 32'(is_valid), 32'd1);
    chk("addi_class", 32'(is_class), 32'd1);
    chk("addi_rd", 32'(is_rd), 32'd1);
    chk("addi_rs1", 32'(is_rs1), 32'd0);
    chk("addi_imm", is_imm, 32'd5);
    chk("addi_wen", 32'(is_rd_wen), 32'd1);
    cycle(0, 32'h0, 1);
    chk("addi_empty", 32'(id_vacant), 32'd1);

    cycle(1, 32'hFE209CE3, 0);
    chk("bne_class", 32'(is_class), 32'd4);
    chk("bne_rs", {22'b0, is_rs1, is_rs2}, {22'b0, 5'd1, 5'd2});
    chk("bne_rd", 32'(is_rd), 32'd0);
    chk("bne_wen", 32'(is_rd_wen), 32'd0);
    chk("bne_imm", is_imm, 32'hFFFF_FFF8);
    cycle(0, 32'h0, 1);

    cycle(1, 32'h022081D7, 0);
    chk("vadd_class", 32'(is_class), 32'd5);
    chk("vadd_regs", {17'b0, is_rd, is_rs1, is_rs2}, {17'b0, 5'd3, 5'd1, 5'd2});
    chk("vadd_vm", 32'(is_vm), 32'd1);
    chk("vadd_vec", {30'b0, is_vec_dst, is_vec_src}, 32'd3);
    // Hold: outputs stable, not vacant, while dispatch stalls.
    repeat (3) begin
      cycle(0, 32'h0, 0);
      chk("hold_vacant", 32'(id_vacant), 32'd0);
      chk("hold_rd", 32'(is_rd), 32'd3);
    end
    cycle(0, 32'h0, 1);
    chk("release_vacant", 32'(id_vacant), 32'd1);

    cycle(1, 32'h0000006F, 0);
    chk("jal_valid", 32'(is_valid), 32'd1);
    chk("jal_illegal", 32'(is_illegal), 32'd1);
    chk("jal_class", 32'(is_class), 32'd0);
    chk("jal_enables", {27'b0, is_rd_wen, is_rs1_used, is_rs2_used, is_vec_dst, is_vec_src},
        32'd0);

    // Asynchronous reset while full, between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(is_valid), 32'd0);
    chk("arst_vacant", 32'(id_vacant), 32'd1);
    chk("arst_class", 32'(is_class), 32'd0);
    exp_full = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    cycle(1, 32'h00500093, 0);
    chk("post_rst_class", 32'(is_class), 32'd1);
    chk("post_rst_imm", is_imm, 32'd5);
    cycle(0, 32'h0, 1);

    for (int n = 0; n < 600; n++) begin
      bit send;
      send = !exp_full && ($urandom_range(0, 2) != 0);
      cycle(send, send ? rand_inst() : $urandom, 1'($urandom_range(0, 1)));
    end
    cycle(0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
